gci_std_ps2_mc: RTL

Multi-channel PS/2 input controller: the parametrised successor of the single-keyboard KMC for GCI device nodes. It has CHANNELS independent PS/2 receivers, for example keyboard plus mouse. Each channel has its own frame checker, scancode FIFO, control/status registers and interrupt source. It sits on the GCI device data bus and IRQ port, and serves the GCI special memory (0x000–0x3FF) through the existing gci_device_special_memory submodule.

---
 rtl/gci_std_ps2_mc_if.sv | 21 ++
 rtl/gci_std_ps2_mc.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gci_std_ps2_mc_if.sv
// GCI device-node bus port of the multi-channel PS/2 controller: request/response
// channel plus the IRQ port. The node drives through master, the controller is the slave.
interface gci_std_ps2_mc_if;
    logic        req;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy_down;
    logic        busy_up;
    logic        rsp_valid;
    logic [31:0] rdata;
    logic        irq_req;
    logic        irq_busy;
    logic        irq_ack;
    logic [23:0] irq_data;

    modport master (output req, rw, addr, wdata, busy_down, irq_busy, irq_ack,
                    input  busy_up, rsp_valid, rdata, irq_req, irq_data);
    modport slave  (input  req, rw, addr, wdata, busy_down, irq_busy, irq_ack,
                    output busy_up, rsp_valid, rdata, irq_req, irq_data);
endinterface

// File: rtl/gci_std_ps2_mc.sv
// Multi-channel PS/2 receiver for GCI device nodes: per-channel frame checker, scancode
// FIFO, CTRL/STATUS registers and IRQ source, plus the GCI special memory window.
module gci_device_special_memory #(
    parameter logic [31:0] USEMEMSIZE = 32'h0000_0420,
    parameter logic [31:0] PRIORITY   = 32'h0000_0000,
    parameter logic [31:0] DEVICECAT  = 32'h0000_0000
) (
    input  logic        iCLOCK,
    input  logic        req,
    input  logic        rw,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata
);
    logic [31:0] mem [256];

    // NOTE: storage arrays are left unreset; only control state needs a known value after reset.
    always_ff @(posedge iCLOCK) begin
        if (req && rw) begin
            mem[addr] <= wdata;
        end
    end

    // Identification words are fixed; everything else is scratch storage for the node.
    always_comb begin
        case (addr)
            8'd0:    rdata = USEMEMSIZE;
            8'd1:    rdata = PRIORITY;
            8'd3:    rdata = DEVICECAT;
            default: rdata = mem[addr];
        endcase
    end
endmodule

module gci_std_ps2_mc #(
    parameter int CHANNELS     = 2,
    parameter int FIFO_DEPTH   = 32,
    parameter int FIFO_DEPTH_N = 5,
    parameter int TIMEOUT      = 20000,
    parameter int TIMEOUT_N    = 15
) (
    input  logic                iCLOCK,
    input  logic                inRESET,
    gci_std_ps2_mc_if.slave     bus,
    input  logic [CHANNELS-1:0] ps2_clock,
    input  logic [CHANNELS-1:0] ps2_data
);
    localparam logic [31:0] REG_BASE  = 32'h0000_0400;
    localparam logic [31:0] MEM_LIMIT = REG_BASE + 32'(CHANNELS) * 32'h10;

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} rx_state_t;

    logic                      spec_hit, reg_hit, any_hit, rd, wr, intflag_rd;
    logic [1:0]                reg_ch;
    logic [3:0]                reg_off;
    logic [31:0]               spec_rdata, rd_val, rsp_data;
    logic                      rsp_valid;
    logic [CHANNELS-1:0]       pending;
    logic [CHANNELS-1:0][31:0] ch_rdata;
    logic                      unused_ok;

    assign spec_hit   = bus.addr < REG_BASE;
    assign reg_hit    = (bus.addr >= REG_BASE) && (bus.addr < MEM_LIMIT);
    assign any_hit    = spec_hit || reg_hit;
    assign rd         = bus.req && !bus.rw;
    assign wr         = bus.req && bus.rw;
    assign reg_ch     = bus.addr[5:4];
    assign reg_off    = bus.addr[3:0];
    assign intflag_rd = rd && spec_hit && (bus.addr[9:2] == 8'd2);
    assign unused_ok  = &{1'b0, bus.irq_ack};

    gci_device_special_memory #(
        .USEMEMSIZE(MEM_LIMIT)
    ) u_special (
        .iCLOCK (iCLOCK),
        .req    (bus.req && spec_hit),
        .rw     (bus.rw),
        .addr   (bus.addr[9:2]),
        .wdata  (bus.wdata),
        .rdata  (spec_rdata)
    );

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        logic                    sel, data_rd, stat_wr, ctrl_wr, flush;
        logic                    rx_en, irq_en, ovf, pend;
        logic [2:0]              clk_sync;
        logic [1:0]              dat_sync;
        logic                    fall, bit_in;
        rx_state_t               state, state_nxt;
        logic [2:0]              bit_cnt, cnt_nxt;
        logic [7:0]              shift, shift_nxt;
        logic                    perr, perr_nxt, done, done_nxt;
        logic [TIMEOUT_N-1:0]    tmo;
        logic [8:0]              fifo_mem [FIFO_DEPTH];
        logic [FIFO_DEPTH_N-1:0] wptr, rptr;
        logic [FIFO_DEPTH_N:0]   count;
        logic                    empty, full, pop, accept, push, drop;
        logic [31:0]             rd_val_ch;

        assign sel     = reg_hit && (reg_ch == 2'(n));
        assign data_rd = rd && sel && (reg_off == 4'h0);
        assign stat_wr = wr && sel && (reg_off == 4'h4);
        assign ctrl_wr = wr && sel && (reg_off == 4'h8);
        assign flush   = ctrl_wr && bus.wdata[2];

        // clk_sync[2] is the synchronised clock delayed once more, for falling-edge detect.
        always_ff @(posedge iCLOCK or negedge inRESET) begin
            if (!inRESET) begin
                clk_sync <= 3'b111;
                dat_sync <= 2'b11;
            end else begin
                clk_sync <= {clk_sync[1:0], ps2_clock[n]};
                dat_sync <= {dat_sync[0], ps2_data[n]};
            end
        end
        assign fall   = clk_sync[2] && !clk_sync[1];
        assign bit_in = dat_sync[1];

        always_ff @(posedge iCLOCK or negedge inRESET) begin
            if (!inRESET) begin
                state   <= S_IDLE;
                bit_cnt <= 3'd0;
                shift   <= 8'd0;
                perr    <= 1'b0;
                done    <= 1'b0;
            end else begin
                state   <= state_nxt;
                bit_cnt <= cnt_nxt;
                shift   <= shift_nxt;
                perr    <= perr_nxt;
                done    <= done_nxt;
            end
        end

        // NOTE: every output of this block gets a default first, so no path infers a latch.
        always_comb begin
            state_nxt = state;
            cnt_nxt   = bit_cnt;
            shift_nxt = shift;
            perr_nxt  = perr;
            done_nxt  = 1'b0;
            if (!rx_en) begin
                state_nxt = S_IDLE;
            end else if (fall) begin
                unique case (state)
                    S_IDLE: begin
                        if (!bit_in) begin
                            state_nxt = S_DATA;
                            cnt_nxt   = 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_nxt = {bit_in, shift[7:1]};
                        cnt_nxt   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) state_nxt = S_PARITY;
                    end
                    S_PARITY: begin
                        perr_nxt  = ~^{shift, bit_in};
                        state_nxt = S_STOP;
                    end
                    S_STOP: begin
                        done_nxt  = bit_in;
                        state_nxt = S_IDLE;
                    end
                endcase
            end else if (state != S_IDLE && tmo == TIMEOUT_N'(TIMEOUT)) begin
                state_nxt = S_IDLE;
            end
        end

        always_ff @(posedge iCLOCK or negedge inRESET) begin
            if (!inRESET) begin
                tmo <= '0;
            end else if (!rx_en || fall || state == S_IDLE) begin
                tmo <= '0;
            end else if (tmo != TIMEOUT_N'(TIMEOUT)) begin
                tmo <= tmo + TIMEOUT_N'(1);
            end
        end

        // A full FIFO still accepts a frame when the same cycle pops an entry.
        assign empty  = (count == '0);
        assign full   = (count == (FIFO_DEPTH_N+1)'(FIFO_DEPTH));
        assign pop    = data_rd && !empty;
        assign accept = done && (!full || pop);
        assign push   = accept && !flush;
        assign drop   = done && !accept;

        always_ff @(posedge iCLOCK) begin
            if (push) fifo_mem[wptr] <= {perr, shift};
        end

        always_ff @(posedge iCLOCK or negedge inRESET) begin
            if (!inRESET) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else if (flush) begin
                wptr  <= '0;
                rptr  <= '0;
                count <= '0;
            end else begin
                if (push) wptr <= wptr + FIFO_DEPTH_N'(1);
                if (pop)  rptr <= rptr + FIFO_DEPTH_N'(1);
                if (push && !pop)      count <= count + (FIFO_DEPTH_N+1)'(1);
                else if (pop && !push) count <= count - (FIFO_DEPTH_N+1)'(1);
            end
        end

        always_ff @(posedge iCLOCK or negedge inRESET) begin
            if (!inRESET) begin
                rx_en  <= 1'b1;
                irq_en <= 1'b1;
                ovf    <= 1'b0;
                pend   <= 1'b0;
            end else begin
                if (ctrl_wr) begin
                    rx_en  <= bus.wdata[0];
                    irq_en <= bus.wdata[1];
                end
                if (drop)                         ovf <= 1'b1;
                else if (stat_wr && bus.wdata[2]) ovf <= 1'b0;
                if (push && irq_en)  pend <= 1'b1;
                else if (intflag_rd) pend <= 1'b0;
            end
        end

        always_comb begin
            rd_val_ch = '0;
            if (sel) begin
                case (reg_off)
                    4'h0:    rd_val_ch = empty ? 32'd0
                                       : {22'd0, fifo_mem[rptr][8], 1'b1, fifo_mem[rptr][7:0]};
                    4'h4:    rd_val_ch = {16'd0, 8'(count), 5'd0, ovf, full, empty};
                    4'h8:    rd_val_ch = {30'd0, irq_en, rx_en};
                    default: rd_val_ch = '0;
                endcase
            end
        end

        assign ch_rdata[n] = rd_val_ch;
        assign pending[n]  = pend;
    end

    // Unselected channels contribute zero, so the register read mux is a plain OR.
    always_comb begin
        rd_val = '0;
        if (spec_hit) begin
            rd_val = (bus.addr[9:2] == 8'd2) ? 32'(pending) : spec_rdata;
        end else begin
            for (int i = 0; i < CHANNELS; i++) rd_val = rd_val | ch_rdata[i];
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= bus.req && any_hit;
            rsp_data  <= (rd && any_hit) ? rd_val : 32'd0;
        end
    end

    assign bus.rsp_valid = rsp_valid;
    assign bus.rdata     = rsp_data;
    assign bus.busy_up   = bus.busy_down;
    assign bus.irq_req   = (|pending) && !bus.irq_busy;
    assign bus.irq_data  = 24'(pending);
endmodule
